// File: rtl/game_pkg.sv
// Shared types and default constants for the game controller.
package game_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StReady   = 3'd1,
        StPlay    = 3'd2,
        StDying   = 3'd3,
        StLevelUp = 3'd4,
        StOver    = 3'd5
    } game_state_t;

    localparam int unsigned DefStartLives  = 3;
    localparam int unsigned DefReadyFrames = 60;
    localparam int unsigned DefDeathFrames = 120;
    localparam int unsigned DefClearFrames = 90;
    localparam int unsigned DefMaxLevel    = 15;
    localparam int unsigned LivesCap       = 5;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Counts frame ticks since the last clear; done pulses on the tick that matches tc_i.
module frame_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             frame_tick_i,
    input  logic [Width-1:0] tc_i,
    output logic             done_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // done must not depend on clear_i: the owner derives clear from the state it selects via done.
    assign done_o = frame_tick_i & (cnt_q == tc_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (frame_tick_i) begin
            cnt_d = done_o ? '0 : cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Top-level game flow FSM: start, ready, play, death, level-clear and game-over sequencing.
// Optional feature: define GAME_EXTRA_LIFE_EN to award a life (capped at 5) on each level clear.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned START_LIVES  = DefStartLives,
    parameter int unsigned READY_FRAMES = DefReadyFrames,
    parameter int unsigned DEATH_FRAMES = DefDeathFrames,
    parameter int unsigned CLEAR_FRAMES = DefClearFrames,
    parameter int unsigned MAX_LEVEL    = DefMaxLevel
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       collide,
    input  logic       pellets_clear,
    output logic [2:0] state,
    output logic       play_en,
    output logic       respawn,
    output logic [2:0] lives,
    output logic [3:0] level,
    output logic       game_over
);

    localparam int unsigned MaxFrames = max3(READY_FRAMES, DEATH_FRAMES, CLEAR_FRAMES);
    localparam int unsigned FrameW    = (MaxFrames > 1) ? $clog2(MaxFrames) : 1;

    game_state_t       state_q, state_d;
    logic [2:0]        lives_q, lives_d;
    logic [3:0]        level_q, level_d;
    logic              play_en_q, play_en_d;
    logic              respawn_q, respawn_d;
    logic              game_over_q, game_over_d;
    logic              start_q;
    logic              start;
    logic              timer_clear;
    logic              timer_done;
    logic [FrameW-1:0] timer_tc;

    assign start       = start_btn & ~start_q;
    assign timer_clear = (state_d != state_q);

    always_comb begin
        unique case (state_q)
            StReady:   timer_tc = FrameW'(READY_FRAMES - 1);
            StDying:   timer_tc = FrameW'(DEATH_FRAMES - 1);
            StLevelUp: timer_tc = FrameW'(CLEAR_FRAMES - 1);
            default:   timer_tc = '1;
        endcase
    end

    frame_timer #(
        .Width (FrameW)
    ) u_frame_timer (
        .clk_i        (Clk),
        .rst_i        (Reset),
        .clear_i      (timer_clear),
        .frame_tick_i (frame_tick),
        .tc_i         (timer_tc),
        .done_o       (timer_done)
    );

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        level_d   = level_q;
        respawn_d = 1'b0;
        unique case (state_q)
            StIdle, StOver: begin
                if (start) begin
                    state_d   = StReady;
                    lives_d   = 3'(START_LIVES);
                    level_d   = 4'd1;
                    respawn_d = 1'b1;
                end
            end
            StReady: begin
                if (timer_done) state_d = StPlay;
            end
            StPlay: begin
                // A level clear outranks a simultaneous collision.
                if (pellets_clear) begin
                    state_d = StLevelUp;
                end else if (collide) begin
                    state_d = StDying;
                    if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
                end
            end
            StDying: begin
                if (timer_done) begin
                    if (lives_q == 3'd0) begin
                        state_d = StOver;
                    end else begin
                        state_d   = StReady;
                        respawn_d = 1'b1;
                    end
                end
            end
            StLevelUp: begin
                if (timer_done) begin
                    state_d   = StReady;
                    respawn_d = 1'b1;
                    if (level_q < 4'(MAX_LEVEL)) level_d = level_q + 4'd1;
`ifdef GAME_EXTRA_LIFE_EN
                    if (lives_q < 3'(LivesCap)) lives_d = lives_q + 3'd1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
        play_en_d   = (state_d == StPlay);
        game_over_d = (state_d == StOver);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            lives_q     <= '0;
            level_q     <= '0;
            play_en_q   <= 1'b0;
            respawn_q   <= 1'b0;
            game_over_q <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            play_en_q   <= play_en_d;
            respawn_q   <= respawn_d;
            game_over_q <= game_over_d;
            start_q     <= start_btn;
        end
    end

    assign state     = state_q;
    assign lives     = lives_q;
    assign level     = level_q;
    assign play_en   = play_en_q;
    assign respawn   = respawn_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl; expects lives +1 per clear when GAME_EXTRA_LIFE_EN is set.
module tb_game_ctrl;

    localparam logic [2:0] SIdle = 3'd0, SReady = 3'd1, SPlay = 3'd2;
    localparam logic [2:0] SDying = 3'd3, SLevelUp = 3'd4, SOver = 3'd5;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       collide = 1'b0;
    logic       pellets_clear = 1'b0;
    logic [2:0] state;
    logic       play_en;
    logic       respawn;
    logic [2:0] lives;
    logic [3:0] level;
    logic       game_over;

    int checks = 0;
    int failures = 0;
    int exp_lives = 0;
    int exp_level = 0;

    always #5 Clk = ~Clk;

    game_ctrl dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_tick    (frame_tick),
        .start_btn     (start_btn),
        .collide       (collide),
        .pellets_clear (pellets_clear),
        .state         (state),
        .play_en       (play_en),
        .respawn       (respawn),
        .lives         (lives),
        .level         (level),
        .game_over     (game_over)
    );

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        frame_tick = 1'b0;
    endtask

    function automatic int gain_life(input int l);
`ifdef GAME_EXTRA_LIFE_EN
        return (l < 5) ? l + 1 : 5;
`else
        return l;
`endif
    endfunction

    task automatic test_reset();
        Reset = 1'b1;
        cyc();
        checks++;
        if ({state, lives, level, play_en, respawn, game_over} !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: got st=%0d lives=%0d lvl=%0d pe=%b rs=%b go=%b want all 0",
                     state, lives, level, play_en, respawn, game_over);
        end
        Reset = 1'b0;
        cyc();
        checks++;
        if (state !== SIdle) begin
            failures++;
            $display("FAIL idle_after_reset: got %0d want %0d", state, SIdle);
        end
    endtask

    task automatic test_start();
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        exp_lives = 3;
        exp_level = 1;
        checks++;
        if (state !== SReady || lives !== 3'(exp_lives) || level !== 4'(exp_level) || respawn !== 1'b1) begin
            failures++;
            $display("FAIL start: got st=%0d lives=%0d lvl=%0d rs=%b want st=1 lives=3 lvl=1 rs=1",
                     state, lives, level, respawn);
        end
        collide = 1'b1;
        pellets_clear = 1'b1;
        cyc();
        collide = 1'b0;
        pellets_clear = 1'b0;
        checks++;
        if (state !== SReady || lives !== 3'd3 || respawn !== 1'b0) begin
            failures++;
            $display("FAIL ready_ignores: got st=%0d lives=%0d rs=%b want st=1 lives=3 rs=0",
                     state, lives, respawn);
        end
        ticks(59);
        checks++;
        if (state !== SReady || play_en !== 1'b0) begin
            failures++;
            $display("FAIL ready_59: got st=%0d pe=%b want st=1 pe=0", state, play_en);
        end
        ticks(1);
        checks++;
        if (state !== SPlay || play_en !== 1'b1) begin
            failures++;
            $display("FAIL ready_to_play: got st=%0d pe=%b want st=2 pe=1", state, play_en);
        end
    endtask

    task automatic test_death();
        collide = 1'b1;
        cyc();
        collide = 1'b0;
        exp_lives = exp_lives - 1;
        checks++;
        if (state !== SDying || lives !== 3'(exp_lives) || play_en !== 1'b0) begin
            failures++;
            $display("FAIL die: got st=%0d lives=%0d pe=%b want st=3 lives=%0d pe=0",
                     state, lives, play_en, exp_lives);
        end
        ticks(119);
        checks++;
        if (state !== SDying) begin
            failures++;
            $display("FAIL dying_119: got %0d want %0d", state, SDying);
        end
        ticks(1);
        checks++;
        if (state !== SReady || respawn !== 1'b1) begin
            failures++;
            $display("FAIL dying_exit: got st=%0d rs=%b want st=1 rs=1", state, respawn);
        end
        cyc();
        checks++;
        if (respawn !== 1'b0) begin
            failures++;
            $display("FAIL respawn_width: got %b want 0", respawn);
        end
        ticks(60);
    endtask

    task automatic test_clear_priority();
        collide = 1'b1;
        pellets_clear = 1'b1;
        cyc();
        collide = 1'b0;
        pellets_clear = 1'b0;
        checks++;
        if (state !== SLevelUp || lives !== 3'(exp_lives)) begin
            failures++;
            $display("FAIL clear_wins: got st=%0d lives=%0d want st=4 lives=%0d",
                     state, lives, exp_lives);
        end
        ticks(90);
        exp_level = 2;
        exp_lives = gain_life(exp_lives);
        checks++;
        if (state !== SReady || level !== 4'(exp_level) || lives !== 3'(exp_lives) || respawn !== 1'b1) begin
            failures++;
            $display("FAIL clear_exit: got st=%0d lvl=%0d lives=%0d rs=%b want st=1 lvl=%0d lives=%0d rs=1",
                     state, level, lives, respawn, exp_level, exp_lives);
        end
        ticks(60);
    endtask

    task automatic test_game_over();
        while (exp_lives > 0) begin
            collide = 1'b1;
            cyc();
            collide = 1'b0;
            exp_lives--;
            checks++;
            if (state !== SDying || lives !== 3'(exp_lives)) begin
                failures++;
                $display("FAIL die_loop: got st=%0d lives=%0d want st=3 lives=%0d",
                         state, lives, exp_lives);
            end
            ticks(120);
            if (exp_lives == 0) begin
                checks++;
                if (state !== SOver || game_over !== 1'b1 || respawn !== 1'b0) begin
                    failures++;
                    $display("FAIL over: got st=%0d go=%b rs=%b want st=5 go=1 rs=0",
                             state, game_over, respawn);
                end
            end else begin
                checks++;
                if (state !== SReady || respawn !== 1'b1) begin
                    failures++;
                    $display("FAIL die_respawn: got st=%0d rs=%b want st=1 rs=1", state, respawn);
                end
                ticks(60);
            end
        end
        collide = 1'b1;
        ticks(130);
        collide = 1'b0;
        checks++;
        if (state !== SOver || lives !== 3'd0) begin
            failures++;
            $display("FAIL over_holds: got st=%0d lives=%0d want st=5 lives=0", state, lives);
        end
    endtask

    task automatic test_back_to_back();
        start_btn = 1'b1;
        cyc();
        exp_lives = 3;
        exp_level = 1;
        checks++;
        if (state !== SReady || lives !== 3'd3 || level !== 4'd1 || respawn !== 1'b1 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL restart: got st=%0d lives=%0d lvl=%0d rs=%b go=%b want st=1 lives=3 lvl=1 rs=1 go=0",
                     state, lives, level, respawn, game_over);
        end
        ticks(60);
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (state !== SPlay || respawn !== 1'b0) begin
                failures++;
                $display("FAIL held_start: got st=%0d rs=%b want st=2 rs=0", state, respawn);
            end
        end
        start_btn = 1'b0;
    endtask

    task automatic test_level_sat();
        while (exp_level < 15) begin
            pellets_clear = 1'b1;
            cyc();
            pellets_clear = 1'b0;
            ticks(90);
            exp_level++;
            exp_lives = gain_life(exp_lives);
            ticks(60);
        end
        checks++;
        if (level !== 4'd15 || lives !== 3'(exp_lives) || state !== SPlay) begin
            failures++;
            $display("FAIL level_15: got lvl=%0d lives=%0d st=%0d want lvl=15 lives=%0d st=2",
                     level, lives, state, exp_lives);
        end
        pellets_clear = 1'b1;
        cyc();
        pellets_clear = 1'b0;
        ticks(90);
        exp_lives = gain_life(exp_lives);
        checks++;
        if (level !== 4'd15 || lives !== 3'(exp_lives) || state !== SReady) begin
            failures++;
            $display("FAIL level_sat: got lvl=%0d lives=%0d st=%0d want lvl=15 lives=%0d st=1",
                     level, lives, state, exp_lives);
        end
        ticks(60);
    endtask

    task automatic test_reset_mid();
        collide = 1'b1;
        cyc();
        collide = 1'b0;
        ticks(50);
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (state !== SIdle || lives !== 3'd0 || level !== 4'd0 || respawn !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got st=%0d lives=%0d lvl=%0d rs=%b want 0 0 0 0",
                     state, lives, level, respawn);
        end
        cyc();
        Reset = 1'b0;
        frame_tick = 1'b1;
        for (int i = 0; i < 80; i++) begin
            cyc();
            checks++;
            if (state !== SIdle || respawn !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle: got st=%0d rs=%b want st=0 rs=0", state, respawn);
            end
        end
        frame_tick = 1'b0;
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        checks++;
        if (state !== SReady || lives !== 3'd3 || level !== 4'd1) begin
            failures++;
            $display("FAIL start_after_reset: got st=%0d lives=%0d lvl=%0d want 1 3 1",
                     state, lives, level);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_death();
        test_clear_priority();
        test_game_over();
        test_back_to_back();
        test_level_sat();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
- REQ-001 SHALL define parameters:
  - START_LIVES, default 3: lives loaded at game start.
  - READY_FRAMES, default 60: frames held in READY.
  - DEATH_FRAMES, default 120: frames held in DYING.
  - CLEAR_FRAMES, default 90: frames held in LEVEL_UP.
  - MAX_LEVEL, default 15: level saturation value.
- REQ-002 SHALL provide ports:
  - Clk  in  1  system clock.
  - Reset  in  1  asynchronous, active-high.
  - frame_tick  in  1  one-cycle pulse per video frame.
  - start_btn  in  1  raw start key, level.
  - collide  in  1  pac/ghost overlap, level.
  - pellets_clear  in  1  all pellets eaten, level.
  - state  out  3  current game_state_t.
  - play_en  out  1  movement/AI enable.
  - respawn  out  1  one-cycle pulse; reload actor positions.
  - lives  out  3  remaining lives.
  - level  out  4  current level, 1-based.
  - game_over  out  1  high in OVER.

Function
- REQ-003 SHALL implement FSM states IDLE, READY, PLAY, DYING, LEVEL_UP, OVER.
- REQ-004 SHALL rising-edge-detect start_btn internally; "start" means a one-cycle edge.
- REQ-005 IDLE or OVER + start: go to READY; lives=START_LIVES, level=1, respawn pulse, all on the same edge.
- REQ-006 READY exits to PLAY on the edge where frame_tick=1 and the frame count equals READY_FRAMES-1.
- REQ-007 PLAY + pellets_clear: go to LEVEL_UP. PLAY + collide (no pellets_clear): go to DYING and decrement lives on the same edge.
- REQ-008 collide and pellets_clear high in the same cycle: pellets_clear wins; lives unchanged.
- REQ-009 Inputs SHALL be ignored outside PLAY, except start in IDLE/OVER.
- REQ-010 DYING exits after DEATH_FRAMES frames (same rule as REQ-006):
  - lives==0 -> OVER.
  - otherwise -> READY with respawn pulse.
- REQ-011 LEVEL_UP exits after CLEAR_FRAMES frames:
  - level increments, saturating at MAX_LEVEL.
  - respawn pulse; go to READY.
- REQ-012 Frame counter SHALL clear on every state entry and count only frame_tick pulses.
- REQ-013 Outputs SHALL be registered:
  - play_en=1 only in PLAY.
  - game_over=1 only in OVER.
  - respawn high exactly one cycle per transition into READY.
- REQ-014 lives SHALL never underflow. Collide at lives==0 cannot occur, because OVER is entered first.

Reset
- REQ-015 Reset SHALL asynchronously force:
  - state=IDLE, lives=0, level=0.
  - play_en=0, respawn=0, game_over=0.
  - frame counter=0, start edge register=0.
- REQ-016 Reset asserted mid-state (e.g. during DYING) SHALL abandon the state with no respawn pulse.
- REQ-017 After deassertion, the first edge evaluates IDLE.

Configuration
- REQ-018 Macro GAME_EXTRA_LIFE_EN:
  - Defined: each LEVEL_UP exit also increments lives, saturating at 5.
  - Undefined: lives change only on game start and death.

Structure
- REQ-019 Package game_pkg SHALL hold game_state_t (3-bit enum) and default constants for lives, frame counts, MAX_LEVEL and lives cap 5.
- REQ-020 Sub-module frame_timer SHALL be used:
  - Inputs: clear, frame_tick, terminal count.
  - Output: done pulse.
  - One instance, terminal count muxed by state.

Verification
- REQ-021 Reset, then start pulse -> state READY next edge; lives=3, level=1, respawn high 1 cycle; PLAY after 60 frame_ticks.
- REQ-022 In PLAY, collide for 1 cycle -> DYING next edge, lives 3->2, play_en=0; READY plus respawn after 120 frame_ticks.
- REQ-023 Three deaths -> lives=0, OVER after third DYING, game_over=1; start pulse -> READY, lives=3, level=1.
- REQ-024 collide and pellets_clear same cycle with lives=2 -> LEVEL_UP, lives=2; after 90 frames level=2. With GAME_EXTRA_LIFE_EN, lives=3.
- REQ-025 Level 15 clear -> level stays 15. Reset asserted during DYING frame 50 -> IDLE immediately, lives=0, no respawn pulse.
- REQ-026 start_btn held high across OVER->READY->PLAY -> only one game start; no re-entry.
